// File: rtl/param_delay_line.sv
// Parametrised registered delay line: DEPTH stages of WIDTH-bit data with per-stage valid,
// shift enable, synchronous flush, a same-cycle tap mux and an up/down occupancy counter.
module param_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int SEL_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] tap_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] tap_data,
    output logic             tap_valid,
    output logic [CNT_W-1:0] fill_count,
    output logic             full
);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic [WIDTH-1:0] prev_data;
            logic             vld_q;
            logic             vld_d;
            logic             prev_vld;

            if (gi == 0) begin : g_head
                assign prev_data = in_data;
                assign prev_vld  = in_valid;
            end else begin : g_body
                assign prev_data = stage_data[gi-1];
                assign prev_vld  = stage_vld[gi-1];
            end

            always_comb begin
                data_d = data_q;
                vld_d  = vld_q;
                if (flush) begin
                    data_d = '0;
                    vld_d  = 1'b0;
                end else if (enable) begin
                    data_d = prev_data;
                    vld_d  = prev_vld;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    data_q <= data_d;
                    vld_q  <= vld_d;
                end
            end

            assign stage_data[gi] = data_q;
            assign stage_vld[gi]  = vld_q;
        end
    endgenerate

    // Occupancy tracks only what enters stage 0 and what leaves the last stage.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (enable) begin
            if (in_valid && !stage_vld[DEPTH-1]) begin
                count_d = count_q + CNT_W'(1);
            end else if (!in_valid && stage_vld[DEPTH-1]) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Out-of-range selects (non-power-of-2 DEPTH) match no stage and read as zero.
    always_comb begin
        tap_data  = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == SEL_W'(i)) begin
                tap_data  = stage_data[i];
                tap_valid = stage_vld[i];
            end
        end
    end

    assign out_data   = stage_data[DEPTH-1];
    assign out_valid  = stage_vld[DEPTH-1];
    assign fill_count = count_q;
    assign full       = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_param_delay_line.sv
// Bench for param_delay_line: DEPTH=4 and DEPTH=3 instances share stimulus and are checked
// against a queue-based history model, a vector table and hand-written corner sequences.
module tb_param_delay_line;

    typedef struct {
        logic [7:0] d;
        logic       v;
    } item_t;

    typedef struct {
        logic       en;
        logic       fl;
        logic       v;
        logic [7:0] d;
        logic [7:0] eo;
        logic       ev;
        logic [2:0] ef;
        logic       efull;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic [1:0] tap_sel4;
    logic [1:0] tap_sel3;

    logic [7:0] out_data4, tap_data4, out_data3, tap_data3;
    logic       out_valid4, tap_valid4, full4, out_valid3, tap_valid3, full3;
    logic [2:0] fill_count4;
    logic [1:0] fill_count3;

    int errors = 0;
    int checks = 0;

    item_t m4[$];
    item_t m3[$];

    param_delay_line #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .tap_sel(tap_sel4),
        .out_data(out_data4), .out_valid(out_valid4),
        .tap_data(tap_data4), .tap_valid(tap_valid4),
        .fill_count(fill_count4), .full(full4)
    );

    param_delay_line #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .tap_sel(tap_sel3),
        .out_data(out_data3), .out_valid(out_valid3),
        .tap_data(tap_data3), .tap_valid(tap_valid3),
        .fill_count(fill_count3), .full(full3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int popcount(input item_t q[$]);
        int n = 0;
        foreach (q[i]) if (q[i].v) n++;
        return n;
    endfunction

    // The model is simply the last DEPTH samples, newest first.
    task automatic model_clear();
        item_t z;
        z.d = 8'h00;
        z.v = 1'b0;
        m4.delete();
        m3.delete();
        for (int i = 0; i < 4; i++) m4.push_back(z);
        for (int i = 0; i < 3; i++) m3.push_back(z);
    endtask

    task automatic model_edge();
        item_t s;
        if (reset || flush) begin
            model_clear();
        end else if (enable) begin
            s.d = in_data;
            s.v = in_valid;
            m4.push_front(s);
            void'(m4.pop_back());
            m3.push_front(s);
            void'(m3.pop_back());
        end
    endtask

    task automatic check_model(input string tag);
        int p4 = popcount(m4);
        int p3 = popcount(m3);
        check({tag, " d4.out_data"},   out_data4,   m4[3].d);
        check({tag, " d4.out_valid"},  out_valid4,  m4[3].v);
        check({tag, " d4.fill_count"}, fill_count4, p4);
        check({tag, " d4.full"},       full4,       (p4 == 4));
        check({tag, " d4.tap_data"},   tap_data4,   m4[tap_sel4].d);
        check({tag, " d4.tap_valid"},  tap_valid4,  m4[tap_sel4].v);
        check({tag, " d3.out_data"},   out_data3,   m3[2].d);
        check({tag, " d3.out_valid"},  out_valid3,  m3[2].v);
        check({tag, " d3.fill_count"}, fill_count3, p3);
        check({tag, " d3.full"},       full3,       (p3 == 3));
        check({tag, " d3.tap_data"},   tap_data3,   (tap_sel3 < 3) ? m3[tap_sel3].d : 8'h00);
        check({tag, " d3.tap_valid"},  tap_valid3,  (tap_sel3 < 3) ? m3[tap_sel3].v : 1'b0);
    endtask

    task automatic step(input logic en, input logic fl, input logic v, input logic [7:0] d,
                        input string tag);
        enable   = en;
        flush    = fl;
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        model_edge();
        #1;
        check_model(tag);
        $display("%s: en=%0b fl=%0b v=%0b d=%02h -> out=%02h/%0b fill=%0d full=%0b",
                 tag, en, fl, v, d, out_data4, out_valid4, fill_count4, full4);
    endtask

    task automatic push4(input logic [7:0] base, input string tag);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, base + 8'(i), tag);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 3'd1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 3'd3, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h04, 8'h01, 1'b1, 3'd4, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h05, 8'h02, 1'b1, 3'd4, 1'b1};

        tap_sel4 = 2'd0;
        tap_sel3 = 2'd0;

        // Reset held two cycles with live inputs
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b1, 8'hFF, "reset");
        step(1'b1, 1'b0, 1'b1, 8'hFF, "reset");
        reset = 1'b0;
        check("reset out_data", out_data4, 8'h00);
        check("reset out_valid", out_valid4, 1'b0);
        check("reset fill_count", fill_count4, 3'd0);
        check("reset full", full4, 1'b0);

        // Latency and order from the table
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].d, "table");
            check("table out_data", out_data4, tbl[i].eo);
            check("table out_valid", out_valid4, tbl[i].ev);
            check("table fill_count", fill_count4, tbl[i].ef);
            check("table full", full4, tbl[i].efull);
        end

        // Enable stall
        step(1'b0, 1'b1, 1'b0, 8'h00, "flush");
        push4(8'hA0, "fill_a");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0], 8'h55 ^ 8'(i * 37), "stall");
            check("stall out_data", out_data4, 8'hA0);
            check("stall fill_count", fill_count4, 3'd4);
        end
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'hB0, "resume");
            check("resume out_data", out_data4, 8'hA0 + 8'(i));
        end

        // Valid gaps
        step(1'b0, 1'b1, 1'b0, 8'h00, "flush");
        step(1'b1, 1'b0, 1'b1, 8'h10, "gaps");
        step(1'b1, 1'b0, 1'b0, 8'h11, "gaps");
        step(1'b1, 1'b0, 1'b1, 8'h12, "gaps");
        step(1'b1, 1'b0, 1'b1, 8'h13, "gaps");
        check("gaps peak fill", fill_count4, 3'd3);
        check("gaps first out", out_valid4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h14, "gaps");
        check("gaps edge5 out_valid", out_valid4, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, "drain");
        check("drain fill_count", fill_count4, 3'd0);

        // Flush beats enable
        push4(8'hC0, "fill_c");
        step(1'b1, 1'b1, 1'b1, 8'hEE, "flush_en");
        check("flush out_data", out_data4, 8'h00);
        check("flush fill_count", fill_count4, 3'd0);
        check("flush full", full4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tap_sel4 = 2'(i);
            #1;
            check("flush tap_data", tap_data4, 8'h00);
            check("flush tap_valid", tap_valid4, 1'b0);
        end

        // Tap sweep, including the out-of-range select on the DEPTH=3 build
        push4(8'h31, "fill_tap");
        for (int i = 0; i < 4; i++) begin
            tap_sel4 = 2'(i);
            tap_sel3 = 2'(i);
            #1;
            check("tap4 data", tap_data4, 8'h34 - 8'(i));
            check("tap4 valid", tap_valid4, 1'b1);
            check("tap3 data", tap_data3, (i < 3) ? 8'h34 - 8'(i) : 8'h00);
            check("tap3 valid", tap_valid3, (i < 3));
            $display("tap_sel=%0d: tap4=%02h tap3=%02h/%0b", i, tap_data4, tap_data3, tap_valid3);
        end

        // Randomised traffic against the history model
        for (int n = 0; n < 400; n++) begin
            tap_sel4 = 2'($urandom_range(0, 3));
            tap_sel3 = 2'($urandom_range(0, 3));
            reset    = ($urandom_range(0, 99) < 2);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 2) != 0), 8'($urandom), "rand");
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
